program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Byte-stream boot loader that writes the instruction memory through the processor's instruction-load port (insMemEn / insMemAddr / insMemDataIn).
- Holds the core in reset until a complete program image has been written.
- Sits between a byte source (UART receiver or debug bridge, valid/ready) and the processor top level.
- Image format: 2-byte little-endian word count N, then N little-endian 32-bit words. Words are written to word addresses 0..N-1.

Parameters:
WIDTH, 32, data/address width of the instruction-load port
IMEM_DEPTH, 512, instruction memory depth in words; maximum legal N

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; returns block to HEADER_LO
byteIn  input  8  incoming image byte
byteValid  input  1  byteIn valid
byteReady  output  1  loader can accept byteIn this cycle
reload  input  1  in DONE/ERROR, restart load at next edge
insMemEn  output  1  one-cycle write strobe to instruction memory
insMemAddr  output  WIDTH  word address (upper bits zero)
insMemDataIn  output  WIDTH  word to write
cpuReset  output  1  reset to processor core; high until load completes
done  output  1  image loaded successfully (sticky)
error  output  1  image rejected (sticky)

Behaviour:
- Reset value of every output and register is 0, except cpuReset = 1. State is HEADER_LO.
- Byte transfer occurs on a rising edge when byteValid & byteReady. byteReady is combinational from state: 1 in HEADER_LO, HEADER_HI, DATA and CHECK; 0 in WRITE, DONE and ERROR. byteIn is don't-care when no transfer occurs. Gaps in byteValid of any length are allowed.
- HEADER_LO: a transfer loads count[7:0] and moves to HEADER_HI.
- HEADER_HI: a transfer loads count[15:8].
  - Complete count = 0: go to DONE.
  - Complete count > IMEM_DEPTH: go to ERROR.
  - Otherwise: clear wordIdx, byteIdx and sum, then go to DATA.
- DATA: each transfer shifts the byte into the assembly register, little-endian (byte 0 goes to bits 7:0).
  - byteIdx increments modulo 4.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - insMemEn = 1, insMemAddr = wordIdx, insMemDataIn = assembled word. All three are registered outputs, valid during this cycle only.
  - wordIdx increments at the end of the cycle.
  - If wordIdx+1 == count: go to DONE (or CHECK when CHECKSUM_EN). Otherwise return to DATA.
- Latency: insMemEn is high in the cycle immediately after the edge that accepted the 4th byte.
- insMemAddr and insMemDataIn hold their last values when insMemEn = 0.
- DONE:
  - cpuReset = 0 and done = 1, both registered, asserted from the first DONE cycle.
  - Bytes are not accepted.
- ERROR:
  - error = 1, cpuReset stays 1, no further writes.
- reload = 1 in DONE or ERROR:
  - Next edge: go to HEADER_LO, cpuReset = 1, done = 0, error = 0.
  - reload is ignored in all other states.
- Asynchronous reset mid-load:
  - Immediate return to HEADER_LO, cpuReset = 1, insMemEn = 0.
  - Partially written memory is not cleared; the next image overwrites it.
- wordIdx and count are 16 bits. insMemAddr = zero-extended wordIdx.

Optional Feature:
CHECKSUM_EN
- Defined:
  - sum accumulates the 8-bit modulo-256 sum of all data bytes; header bytes are excluded.
  - After the last WRITE the FSM enters CHECK and accepts one checksum byte.
  - Checksum byte == sum: go to DONE. Otherwise: go to ERROR, and cpuReset stays 1.
  - For count = 0 the FSM also passes through CHECK, with expected byte 0x00.
- Undefined:
  - No sum register and no CHECK state; the last WRITE goes directly to DONE.

Test Plan:
- Image 02 00 | 13 00 00 00 | 93 01 10 00, byteValid held high -> two insMemEn pulses: addr 0 / data 0x00000013, then addr 1 / data 0x00100193. Each pulse is one cycle after its 4th byte. done = 1 and cpuReset = 0 one cycle after the second pulse.
- Same image with byteValid low for 3 random cycles between bytes -> identical writes; no insMemEn outside WRITE; byteReady = 0 during WRITE.
- Header 00 00 -> DONE after 2 bytes, no writes. Header 01 02 (count 513 > 512) -> error = 1, cpuReset = 1, no writes, byteReady = 0.
- Assert reset after 6 data bytes of a 2-word image -> all outputs at reset values, no pulse for the partial word. A fresh full image then loads correctly from addr 0.
- In DONE, pulse reload, then send image 01 00 | EF BE AD DE -> cpuReset rises the next cycle, done clears, write addr 0 / data 0xDEADBEEF, done = 1 again.
- CHECKSUM_EN, image 01 00 | 01 02 03 04 then checksum 0A -> done. With checksum 0B instead -> error = 1, cpuReset = 1, but the write of 0x04030201 to addr 0 still occurs.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream and instruction-load bundle for the boot loader.
// master = loader side, slave = byte source / core side.
interface program_loader_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       byteIn;
  logic             byteValid;
  logic             byteReady;
  logic             reload;
  logic             insMemEn;
  logic [WIDTH-1:0] insMemAddr;
  logic [WIDTH-1:0] insMemDataIn;
  logic             cpuReset;
  logic             done;
  logic             error;

  modport master (
    input  byteIn,
    input  byteValid,
    input  reload,
    output byteReady,
    output insMemEn,
    output insMemAddr,
    output insMemDataIn,
    output cpuReset,
    output done,
    output error
  );

  modport slave (
    output byteIn,
    output byteValid,
    output reload,
    input  byteReady,
    input  insMemEn,
    input  insMemAddr,
    input  insMemDataIn,
    input  cpuReset,
    input  done,
    input  error
  );
endinterface

// File: rtl/program_loader.sv
// Byte-stream boot loader: header count, LE words into imem, core held in reset.
// Optional trailing checksum byte when CHECKSUM_EN is defined.
module program_loader #(
  parameter int WIDTH      = 32,
  parameter int IMEM_DEPTH = 512
) (
  input logic              clock,
  input logic              reset,
  program_loader_if.master bus
);

  typedef enum logic [2:0] {
    S_HLO,
    S_HHI,
    S_DATA,
    S_WRITE,
`ifdef CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] count;
  logic [15:0] count_n;
  logic [15:0] word_idx;
  logic [15:0] word_idx_n;
  logic [15:0] word_inc;
  logic [15:0] hdr;
  logic [1:0]  byte_idx;
  logic [1:0]  byte_idx_n;
  logic [31:0] asm_q;
  logic [31:0] asm_n;
`ifdef CHECKSUM_EN
  logic [7:0]  sum;
  logic [7:0]  sum_n;
`endif
  logic        ready;
  logic        fire;

  logic             en_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] data_q;
  logic             cpu_rst_q;
  logic             done_q;
  logic             err_q;

  // Byte acceptance depends on state only
  always_comb begin
    ready = 1'b0;
    unique case (state)
      S_HLO,
      S_HHI,
`ifdef CHECKSUM_EN
      S_CHECK,
`endif
      S_DATA:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign fire = bus.byteValid & ready;

  // Next-state and datapath updates
  always_comb begin
    state_n    = state;
    count_n    = count;
    word_idx_n = word_idx;
    byte_idx_n = byte_idx;
    asm_n      = asm_q;
`ifdef CHECKSUM_EN
    sum_n      = sum;
`endif
    hdr        = {bus.byteIn, count[7:0]};
    word_inc   = word_idx + 16'd1;
    unique case (state)
      S_HLO: begin
        if (fire) begin
          count_n[7:0] = bus.byteIn;
          state_n      = S_HHI;
        end
      end
      S_HHI: begin
        if (fire) begin
          count_n    = hdr;
          word_idx_n = 16'd0;
          byte_idx_n = 2'd0;
`ifdef CHECKSUM_EN
          sum_n      = 8'd0;
`endif
          if (hdr == 16'd0) begin
`ifdef CHECKSUM_EN
            state_n = S_CHECK;
`else
            state_n = S_DONE;
`endif
          end else if ({16'd0, hdr} > 32'(IMEM_DEPTH)) begin
            state_n = S_ERROR;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          asm_n      = {bus.byteIn, asm_q[31:8]};
          byte_idx_n = byte_idx + 2'd1;
`ifdef CHECKSUM_EN
          sum_n      = sum + bus.byteIn;
`endif
          if (byte_idx == 2'd3) state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        word_idx_n = word_inc;
        if (word_inc == count) begin
`ifdef CHECKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_DATA;
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (fire) state_n = (bus.byteIn == sum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE,
      S_ERROR: begin
        if (bus.reload) state_n = S_HLO;
      end
      default: state_n = S_HLO;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_HLO;
      count    <= 16'd0;
      word_idx <= 16'd0;
      byte_idx <= 2'd0;
      asm_q    <= 32'd0;
`ifdef CHECKSUM_EN
      sum      <= 8'd0;
`endif
    end else begin
      state    <= state_n;
      count    <= count_n;
      word_idx <= word_idx_n;
      byte_idx <= byte_idx_n;
      asm_q    <= asm_n;
`ifdef CHECKSUM_EN
      sum      <= sum_n;
`endif
    end
  end

  // Registered outputs, driven from the state being entered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      en_q      <= (state_n == S_WRITE);
      if (state_n == S_WRITE) begin
        addr_q <= WIDTH'(word_idx);
        data_q <= WIDTH'(asm_n);
      end
      cpu_rst_q <= (state_n != S_DONE);
      done_q    <= (state_n == S_DONE);
      err_q     <= (state_n == S_ERROR);
    end
  end

  assign bus.byteReady    = ready;
  assign bus.insMemEn     = en_q;
  assign bus.insMemAddr   = addr_q;
  assign bus.insMemDataIn = data_q;
  assign bus.cpuReset     = cpu_rst_q;
  assign bus.done         = done_q;
  assign bus.error        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, hand sequences,
// and random images against an image-level reference model.
module tb_program_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];

  typedef struct {
    logic [7:0]  img [12];
    int          len;
    int          gap;
    logic        ed;
    logic        ee;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  program_loader_if #(.WIDTH(32)) bus();

  program_loader #(
    .WIDTH(32),
    .IMEM_DEPTH(512)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  wq_t  obs;
  wq_t  exp_w;
  logic exp_d;
  logic exp_e;
  logic prev_en = 1'b0;
  vec_t tbl [8];
  int   n_tbl;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, got none expected event", nm);
  endtask

  // write monitor
  always @(negedge clock) begin
    if (bus.insMemEn) begin
      obs.push_back({bus.insMemAddr, bus.insMemDataIn});
      chk("ready_in_write", 64'(bus.byteReady), 64'd0);
      chk("en_one_cycle", 64'(prev_en), 64'd0);
    end
    prev_en = bus.insMemEn;
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.byteIn    = b;
    bus.byteValid = 1'b1;
    while (!bus.byteReady && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!bus.byteReady) begin
      fail_now("byte_accept");
      bus.byteValid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    bus.byteValid = 1'b0;
    bus.byteIn    = 8'h00;
  endtask

  task automatic send_img(input bq_t q, input int gap);
    int g;
    for (int i = 0; i < q.size(); i++) begin
      send_byte(q[i]);
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      if (g > 0 && i != q.size() - 1) begin
        repeat (g) @(posedge clock);
        #1;
      end
    end
  endtask

  // image-level reference: what the loader should write and how it ends
  task automatic model(input bq_t img);
    int cnt;
    logic [7:0] s;
    exp_w.delete();
    s   = 8'd0;
    cnt = int'({img[1], img[0]});
    if (cnt > 512) begin
      exp_d = 1'b0;
      exp_e = 1'b1;
    end else begin
      for (int k = 0; k < cnt; k++) begin
        exp_w.push_back({32'(k), img[4*k+5], img[4*k+4],
                         img[4*k+3], img[4*k+2]});
        for (int j = 0; j < 4; j++) s = s + img[4*k+2+j];
      end
`ifdef CHECKSUM_EN
      exp_d = (img[4*cnt+2] == s);
      exp_e = !exp_d;
`else
      exp_d = 1'b1;
      exp_e = 1'b0;
`endif
    end
  endtask

  task automatic gen_img(input int cnt, input bit bad, output bq_t q);
    logic [7:0] s;
    logic [7:0] b;
    q.delete();
    s = 8'd0;
    q.push_back(cnt[7:0]);
    q.push_back(cnt[15:8]);
    if (cnt <= 512) begin
      for (int i = 0; i < 4 * cnt; i++) begin
        b = 8'($urandom);
        s = s + b;
        q.push_back(b);
      end
`ifdef CHECKSUM_EN
      q.push_back(bad ? s + 8'($urandom_range(1, 255)) : s);
`endif
    end
  endtask

  task automatic finish_check(input string nm);
    int t;
    t = 0;
    while (!(bus.done || bus.error) && t < 60) begin
      @(negedge clock);
      t++;
    end
    if (!(bus.done || bus.error)) fail_now({nm, "_end"});
    @(negedge clock);
    chk({nm, "_done"}, 64'(bus.done), 64'(exp_d));
    chk({nm, "_error"}, 64'(bus.error), 64'(exp_e));
    chk({nm, "_cpuReset"}, 64'(bus.cpuReset), 64'(!exp_d));
    chk({nm, "_ready"}, 64'(bus.byteReady), 64'd0);
    chk({nm, "_nwrites"}, 64'(obs.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < obs.size(); i++)
      chk({nm, "_write"}, obs[i], exp_w[i]);
  endtask

  task automatic do_reload();
    bus.reload = 1'b1;
    @(posedge clock);
    #1;
    bus.reload = 1'b0;
    chk("reload_cpuReset", 64'(bus.cpuReset), 64'd1);
    chk("reload_done", 64'(bus.done), 64'd0);
    chk("reload_error", 64'(bus.error), 64'd0);
    chk("reload_ready", 64'(bus.byteReady), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int  cnt;
    int  r;

`ifdef CHECKSUM_EN
    tbl[0] = '{'{8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h01,
                 8'h10,8'h00,8'hB7,8'h00}, 11, 0, 1'b1, 1'b0, 2,
               32'h00000013, 32'h00100193};
    tbl[1] = '{'{8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h01,
                 8'h10,8'h00,8'hB7,8'h00}, 11, 3, 1'b1, 1'b0, 2,
               32'h00000013, 32'h00100193};
    tbl[2] = '{'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 3, 0, 1'b1, 1'b0, 0,
               32'h0, 32'h0};
    tbl[3] = '{'{8'h01,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 2, 0, 1'b0, 1'b1, 0,
               32'h0, 32'h0};
    tbl[4] = '{'{8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h38,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 7, 0, 1'b1, 1'b0, 1,
               32'hDEADBEEF, 32'h0};
    tbl[5] = '{'{8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h0A,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 7, 1, 1'b1, 1'b0, 1,
               32'h04030201, 32'h0};
    tbl[6] = '{'{8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h0B,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 7, 0, 1'b0, 1'b1, 1,
               32'h04030201, 32'h0};
    n_tbl = 7;
`else
    tbl[0] = '{'{8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h01,
                 8'h10,8'h00,8'h00,8'h00}, 10, 0, 1'b1, 1'b0, 2,
               32'h00000013, 32'h00100193};
    tbl[1] = '{'{8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h01,
                 8'h10,8'h00,8'h00,8'h00}, 10, 3, 1'b1, 1'b0, 2,
               32'h00000013, 32'h00100193};
    tbl[2] = '{'{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 2, 0, 1'b1, 1'b0, 0,
               32'h0, 32'h0};
    tbl[3] = '{'{8'h01,8'h02,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 2, 0, 1'b0, 1'b1, 0,
               32'h0, 32'h0};
    tbl[4] = '{'{8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h00,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 6, 0, 1'b1, 1'b0, 1,
               32'hDEADBEEF, 32'h0};
    tbl[5] = '{'{8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h00,8'h00,
                 8'h00,8'h00,8'h00,8'h00}, 6, 1, 1'b1, 1'b0, 1,
               32'h04030201, 32'h0};
    n_tbl = 6;
`endif

    reset         = 1'b1;
    bus.byteIn    = 8'h00;
    bus.byteValid = 1'b0;
    bus.reload    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cpuReset", 64'(bus.cpuReset), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_en", 64'(bus.insMemEn), 64'd0);
    chk("rst_addr", 64'(bus.insMemAddr), 64'd0);
    chk("rst_data", 64'(bus.insMemDataIn), 64'd0);
    chk("rst_ready", 64'(bus.byteReady), 64'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // write latency and done timing
    obs.delete();
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    send_img(q, 0);
    chk("lat_en0", 64'(bus.insMemEn), 64'd1);
    chk("lat_w0", {bus.insMemAddr, bus.insMemDataIn}, {32'd0, 32'h13});
    q = '{8'h93, 8'h01, 8'h10, 8'h00};
    send_img(q, 0);
    chk("lat_en1", 64'(bus.insMemEn), 64'd1);
    chk("lat_w1", {bus.insMemAddr, bus.insMemDataIn},
        {32'd1, 32'h00100193});
`ifdef CHECKSUM_EN
    send_byte(8'hB7);
`else
    @(posedge clock);
    #1;
`endif
    chk("lat_done", 64'(bus.done), 64'd1);
    chk("lat_cpuReset", 64'(bus.cpuReset), 64'd0);
    chk("lat_held_addr", 64'(bus.insMemAddr), 64'd1);
    do_reload();

    // vector table
    for (int i = 0; i < n_tbl; i++) begin
      obs.delete();
      exp_w.delete();
      q.delete();
      for (int j = 0; j < tbl[i].len; j++) q.push_back(tbl[i].img[j]);
      if (tbl[i].nw > 0) exp_w.push_back({32'd0, tbl[i].w0});
      if (tbl[i].nw > 1) exp_w.push_back({32'd1, tbl[i].w1});
      exp_d = tbl[i].ed;
      exp_e = tbl[i].ee;
      send_img(q, tbl[i].gap);
      finish_check($sformatf("vec%0d", i));
      do_reload();
    end

    // reload is ignored while loading
    obs.delete();
    q = '{8'h01, 8'h00, 8'h11};
    send_img(q, 0);
    bus.reload = 1'b1;
    @(posedge clock);
    #1;
    bus.reload = 1'b0;
    q = '{8'h22, 8'h33, 8'h44};
`ifdef CHECKSUM_EN
    q.push_back(8'hAA);
`endif
    send_img(q, 0);
    model('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA});
    finish_check("reload_ignored");
    do_reload();

    // asynchronous reset mid-load
    obs.delete();
    q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_img(q, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_cpuReset", 64'(bus.cpuReset), 64'd1);
    chk("arst_en", 64'(bus.insMemEn), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_addr", 64'(bus.insMemAddr), 64'd0);
    chk("arst_data", 64'(bus.insMemDataIn), 64'd0);
    chk("arst_ready", 64'(bus.byteReady), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("arst_partial", 64'(obs.size()), 64'd1);
    obs.delete();
    gen_img(2, 1'b0, q);
    model(q);
    send_img(q, -1);
    finish_check("arst_reload");
    do_reload();

    // random images
    for (int it = 0; it < 24; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) cnt = 0;
      else if (r == 1) cnt = int'($urandom_range(513, 65535));
      else cnt = int'($urandom_range(1, 6));
      gen_img(cnt, ($urandom_range(0, 3) == 0), q);
      model(q);
      obs.delete();
      send_img(q, -1);
      finish_check($sformatf("rnd%0d", it));
      do_reload();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
